// File: rtl/serial_byte_capture_pkg.sv
// Shared definitions for the serial byte capture block.
// Holds the default word width, the capture FSM encoding and the
// helper that sizes FIFO fill counters from a buffer depth.
package serial_byte_capture_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A fill counter must represent 0..depth inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/serial_byte_capture_if.sv
// Serial-in / parallel-out bus of the serial byte capture block.
// Ports: ser_in, bit_valid, sync_in (framed bit stream); data_out,
// out_valid, out_ready (word handshake). slave = capture block side.
interface serial_byte_capture_if
    import serial_byte_capture_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             ser_in;
    logic             bit_valid;
    logic             sync_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;

    // Environment side: drives the bit stream, consumes words.
    modport master (
        output ser_in,
        output bit_valid,
        output sync_in,
        output out_ready,
        input  data_out,
        input  out_valid
    );

    // Capture block side.
    modport slave (
        input  ser_in,
        input  bit_valid,
        input  sync_in,
        input  out_ready,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/serial_byte_capture_fifo.sv
// Synchronous first-word-fall-through FIFO for completed words.
// Latency: a push is visible at head_data on the edge it is written.
// Backpressure: push when full is dropped unless a pop occurs the same cycle.
// Ports: clk, rst_n, push, push_data, pop, head_data, empty, full, fill.
module byte_fifo
    import serial_byte_capture_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic                         full,
    output logic [fill_width(DEPTH)-1:0] fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = fill_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FW'(DEPTH));

    // A pop frees the head slot in the same cycle, so a full FIFO can
    // still accept a word when it is being drained.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty FIFO presents zero rather than a stale entry.
    assign head_data = empty ? '0 : mem[rd_ptr];
    assign fill      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth: natural wrap
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_byte_capture.sv
// Deserialises a framed serial bit stream into WIDTH-bit words, buffered in a FWFT FIFO.
// Latency: a completed word is at data_out from its final-bit edge when the FIFO was empty.
// Backpressure: out_ready pops; a word completing into a full FIFO without a pop is dropped (overrun).
// Ports: clk, rst_n, bus (serial in / word out handshake), fill, frame_err, overrun, clear_err.
module serial_byte_capture
    import serial_byte_capture_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    serial_byte_capture_if.slave              bus,
    output logic [fill_width(FIFO_DEPTH)-1:0] fill,
    output logic                              frame_err,
    output logic                              overrun,
    input  logic                              clear_err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;

    logic             last_bit;
    logic             frame_evt;
    logic             overrun_evt;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] next_word;

    // Placement of the first bit of a word and of each subsequent bit.
    assign first_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.ser_in}
                                  : {bus.ser_in, {(WIDTH-1){1'b0}}};
    assign next_word  = MSB_FIRST ? {shreg[WIDTH-2:0], bus.ser_in}
                                  : {bus.ser_in, shreg[WIDTH-1:1]};

    assign last_bit  = (state == SHIFT) && bus.bit_valid && !bus.sync_in
                       && (bit_cnt == CW'(WIDTH-1));
    assign frame_evt = (state == SHIFT) && bus.bit_valid && bus.sync_in;

    // The completing word is pushed straight from the shift path so it is
    // stored on the edge of its final bit; data_out itself comes from FIFO
    // storage, so there is no combinational ser_in-to-data_out path.
    assign push        = last_bit;
    assign pop         = bus.out_valid & bus.out_ready;
    assign overrun_evt = push & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bit_valid && bus.sync_in) begin
                        shreg   <= first_word;
                        bit_cnt <= CW'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.bit_valid) begin
                        if (bus.sync_in) begin
                            // Restart: the partial word is abandoned.
                            shreg   <= first_word;
                            bit_cnt <= CW'(1);
                        end else if (last_bit) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            shreg   <= next_word;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    shreg   <= '0;
                end
            endcase

            // A fresh error outranks a simultaneous clear.
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end

            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (next_word),
        .pop       (pop),
        .head_data (bus.data_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .fill      (fill)
    );

    assign bus.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_serial_byte_capture.sv
module tb_serial_byte_capture;
    logic       clk;
    logic       rst_n;
    logic       clear_err_m;
    logic       clear_err_l;
    logic [1:0] fill_m;
    logic [1:0] fill_l;
    logic       frame_err_m;
    logic       frame_err_l;
    logic       overrun_m;
    logic       overrun_l;

    int n_cmp;
    int n_bad;

    serial_byte_capture_if #(.WIDTH(8)) bus_m ();
    serial_byte_capture_if #(.WIDTH(8)) bus_l ();

    serial_byte_capture #(.WIDTH(8), .MSB_FIRST(1'b1), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_m),
        .fill      (fill_m),
        .frame_err (frame_err_m),
        .overrun   (overrun_m),
        .clear_err (clear_err_m)
    );

    serial_byte_capture #(.WIDTH(8), .MSB_FIRST(1'b0), .FIFO_DEPTH(2)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_l),
        .fill      (fill_l),
        .frame_err (frame_err_l),
        .overrun   (overrun_l),
        .clear_err (clear_err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends nbits bits of seq, seq[7] first; sync on the first one if asked.
    // Returns 1 time unit after the last bit's edge.
    task automatic send_m(input logic [7:0] seq, input int nbits, input logic sync_first);
        for (int i = 0; i < nbits; i++) begin
            bus_m.ser_in    = seq[7-i];
            bus_m.bit_valid = 1'b1;
            bus_m.sync_in   = (i == 0) && sync_first;
            @(posedge clk); #1;
        end
        bus_m.bit_valid = 1'b0;
        bus_m.sync_in   = 1'b0;
        bus_m.ser_in    = 1'b0;
    endtask

    task automatic send_l(input logic [7:0] seq, input int nbits, input logic sync_first);
        for (int i = 0; i < nbits; i++) begin
            bus_l.ser_in    = seq[7-i];
            bus_l.bit_valid = 1'b1;
            bus_l.sync_in   = (i == 0) && sync_first;
            @(posedge clk); #1;
        end
        bus_l.bit_valid = 1'b0;
        bus_l.sync_in   = 1'b0;
        bus_l.ser_in    = 1'b0;
    endtask

    task automatic pop_m();
        bus_m.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_m.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus_m.out_valid); end
        n_cmp++; if (bus_m.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", bus_m.data_out); end
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", fill_m); end
        n_cmp++; if (frame_err_m !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err_m); end
        n_cmp++; if (overrun_m !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun_m); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_assembly();
        // 1,0,1,0,0,1,0,1 -> A5; nothing visible until the 8th bit edge.
        send_m(8'hA5, 7, 1'b1);
        n_cmp++; if (bus_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL msb_early_valid got %b want 0", bus_m.out_valid); end
        send_m({1'b1, 7'b0}, 1, 1'b0);
        n_cmp++; if (bus_m.out_valid !== 1'b1) begin n_bad++; $display("FAIL msb_valid got %b want 1", bus_m.out_valid); end
        n_cmp++; if (bus_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL msb_data got %h want a5", bus_m.data_out); end
        n_cmp++; if (fill_m !== 2'd1) begin n_bad++; $display("FAIL msb_fill got %0d want 1", fill_m); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL msb_hold got %h want a5", bus_m.data_out); end
        pop_m();
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL msb_pop_fill got %0d want 0", fill_m); end
        n_cmp++; if (bus_m.data_out !== 8'h00) begin n_bad++; $display("FAIL msb_empty_data got %h want 00", bus_m.data_out); end
    endtask

    task automatic test_lsb_order();
        send_l(8'b1010_0101, 8, 1'b1);
        n_cmp++; if (bus_l.data_out !== 8'hA5) begin n_bad++; $display("FAIL lsb_a5 got %h want a5", bus_l.data_out); end
        bus_l.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_l.out_ready = 1'b0;
        // 1,1,0,0,0,0,0,0 first-bit-in-LSB -> 03
        send_l(8'b1100_0000, 8, 1'b1);
        n_cmp++; if (bus_l.data_out !== 8'h03) begin n_bad++; $display("FAIL lsb_03 got %h want 03", bus_l.data_out); end
        n_cmp++; if (fill_l !== 2'd1) begin n_bad++; $display("FAIL lsb_fill got %0d want 1", fill_l); end
        bus_l.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_l.out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        send_m(8'hA5, 8, 1'b1);
        send_m(8'h3C, 8, 1'b1);
        n_cmp++; if (overrun_m !== 1'b0) begin n_bad++; $display("FAIL ovr_early got %b want 0", overrun_m); end
        send_m(8'hFF, 8, 1'b1);
        n_cmp++; if (fill_m !== 2'd2) begin n_bad++; $display("FAIL ovr_fill got %0d want 2", fill_m); end
        n_cmp++; if (overrun_m !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", overrun_m); end
        n_cmp++; if (bus_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL ovr_head got %h want a5", bus_m.data_out); end
        bus_m.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus_m.data_out !== 8'h3C) begin n_bad++; $display("FAIL ovr_second got %h want 3c", bus_m.data_out); end
        @(posedge clk); #1;
        n_cmp++; if (bus_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drained got %b want 0", bus_m.out_valid); end
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL ovr_drain_fill got %0d want 0", fill_m); end
        bus_m.out_ready = 1'b0;
        clear_err_m = 1'b1;
        @(posedge clk); #1;
        clear_err_m = 1'b0;
        n_cmp++; if (overrun_m !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b want 0", overrun_m); end
    endtask

    task automatic test_frame_restart();
        send_m(8'b1110_0000, 3, 1'b1);
        n_cmp++; if (frame_err_m !== 1'b0) begin n_bad++; $display("FAIL frm_early got %b want 0", frame_err_m); end
        send_m(8'h5A, 8, 1'b1);
        n_cmp++; if (frame_err_m !== 1'b1) begin n_bad++; $display("FAIL frm_flag got %b want 1", frame_err_m); end
        n_cmp++; if (bus_m.data_out !== 8'h5A) begin n_bad++; $display("FAIL frm_data got %h want 5a", bus_m.data_out); end
        n_cmp++; if (fill_m !== 2'd1) begin n_bad++; $display("FAIL frm_fill got %0d want 1", fill_m); end
        clear_err_m = 1'b1;
        @(posedge clk); #1;
        clear_err_m = 1'b0;
        n_cmp++; if (frame_err_m !== 1'b0) begin n_bad++; $display("FAIL frm_clear got %b want 0", frame_err_m); end
        pop_m();
        // Restart coinciding with clear_err: the new error must stick.
        send_m(8'b1100_0000, 2, 1'b1);
        clear_err_m = 1'b1;
        send_m(8'h5A, 1, 1'b1);
        clear_err_m = 1'b0;
        send_m({8'h5A << 1}, 7, 1'b0);
        n_cmp++; if (frame_err_m !== 1'b1) begin n_bad++; $display("FAIL frm_clear_race got %b want 1", frame_err_m); end
        n_cmp++; if (bus_m.data_out !== 8'h5A) begin n_bad++; $display("FAIL frm_race_data got %h want 5a", bus_m.data_out); end
        pop_m();
        clear_err_m = 1'b1;
        @(posedge clk); #1;
        clear_err_m = 1'b0;
    endtask

    task automatic test_full_push_pop();
        send_m(8'h11, 8, 1'b1);
        send_m(8'h22, 8, 1'b1);
        n_cmp++; if (fill_m !== 2'd2) begin n_bad++; $display("FAIL fpp_full got %0d want 2", fill_m); end
        send_m(8'h33, 7, 1'b1);
        bus_m.out_ready = 1'b1;
        send_m({8'h33 << 7}, 1, 1'b0);
        bus_m.out_ready = 1'b0;
        n_cmp++; if (overrun_m !== 1'b0) begin n_bad++; $display("FAIL fpp_overrun got %b want 0", overrun_m); end
        n_cmp++; if (fill_m !== 2'd2) begin n_bad++; $display("FAIL fpp_fill got %0d want 2", fill_m); end
        n_cmp++; if (bus_m.data_out !== 8'h22) begin n_bad++; $display("FAIL fpp_head1 got %h want 22", bus_m.data_out); end
        pop_m();
        n_cmp++; if (bus_m.data_out !== 8'h33) begin n_bad++; $display("FAIL fpp_head2 got %h want 33", bus_m.data_out); end
        pop_m();
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL fpp_empty got %0d want 0", fill_m); end
    endtask

    task automatic test_reset_mid();
        send_m(8'h11, 8, 1'b1);
        send_m(8'hC3, 5, 1'b1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", bus_m.out_valid); end
        n_cmp++; if (bus_m.data_out !== 8'h00) begin n_bad++; $display("FAIL rstmid_data got %h want 00", bus_m.data_out); end
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL rstmid_fill got %0d want 0", fill_m); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Unsynced bits after reset must be ignored; the partial word is gone.
        send_m(8'hFF, 3, 1'b0);
        n_cmp++; if (fill_m !== 2'd0) begin n_bad++; $display("FAIL rstmid_ignore got %0d want 0", fill_m); end
        send_m(8'hC3, 8, 1'b1);
        n_cmp++; if (bus_m.data_out !== 8'hC3) begin n_bad++; $display("FAIL post_rst_data got %h want c3", bus_m.data_out); end
        n_cmp++; if (fill_m !== 2'd1) begin n_bad++; $display("FAIL post_rst_fill got %0d want 1", fill_m); end
        n_cmp++; if (frame_err_m !== 1'b0) begin n_bad++; $display("FAIL post_rst_frame got %b want 0", frame_err_m); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_err_m = 1'b0;
        clear_err_l = 1'b0;
        bus_m.ser_in = 1'b0; bus_m.bit_valid = 1'b0; bus_m.sync_in = 1'b0; bus_m.out_ready = 1'b0;
        bus_l.ser_in = 1'b0; bus_l.bit_valid = 1'b0; bus_l.sync_in = 1'b0; bus_l.out_ready = 1'b0;

        test_reset();
        test_msb_assembly();
        test_lsb_order();
        test_overrun();
        test_frame_restart();
        test_full_push_pop();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
